// File: rtl/status_array_sweeper.sv
// Purpose: clears every masked status-array bank after reset and again on each flush request (optional macro SWEEP_RANGE_EN adds per-request base/count).
// Latency: first beat 1 edge after entering SWEEP, o_flush_done count+1 edges after entering SWEEP (plus stall/halt cycles).
// Backpressure: beat fields hold while i_wr_ready=0; i_halt freezes all state and outputs; requests taken only when o_ready=1.
module status_array_sweeper #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROW_WIDTH  = 8,
    parameter int NUM_BLOCKS = 4,
    parameter int NUM_BANKS  = 2,
    parameter logic [ROW_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_flush_req,
    input  logic [NUM_BANKS-1:0]  i_flush_bank_mask,
`ifdef SWEEP_RANGE_EN
    input  logic [ADDR_WIDTH-1:0] i_flush_base,
    input  logic [ADDR_WIDTH:0]   i_flush_count,
`endif
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic                  o_wen,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic [NUM_BANKS-1:0]  o_bank_sel,
    output logic                  o_valid,
    output logic                  o_init_complete,
    output logic                  o_ready,
    output logic                  o_flush_done
);

    localparam logic [1:0] ST_UNINIT = 2'd0;
    localparam logic [1:0] ST_SWEEP  = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [NUM_BANKS-1:0]  mask_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic                  xfer;
    logic                  accept;
    logic                  more;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [ADDR_WIDTH:0]   req_count;

    // Request parameters: range build clamps the count to one full pass of the array
`ifdef SWEEP_RANGE_EN
    assign req_base  = i_flush_base;
    assign req_count = (i_flush_count > FULL_COUNT) ? FULL_COUNT : i_flush_count;
`else
    assign req_base  = '0;
    assign req_count = FULL_COUNT;
`endif

    assign o_ready   = (state == ST_READY) && !i_halt;
    assign o_wen     = o_valid;
    assign accept    = i_flush_req & o_ready;
    assign xfer      = o_valid & i_wr_ready;
    assign cnt_next  = cnt + {{ADDR_WIDTH{1'b0}}, xfer};
    // A zero bank mask behaves like a zero count: the sweep runs but issues no beats
    assign more      = (cnt_next < count_q) && (mask_q != '0);
    // Address wraps naturally at DEPTH through the truncating add
    assign addr_next = base_q + cnt_next[ADDR_WIDTH-1:0];

    // Sweep sequencer; i_halt acts as a common enable so every register freezes together
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= ST_UNINIT;
            cnt             <= '0;
            mask_q          <= '0;
            base_q          <= '0;
            count_q         <= '0;
            o_addr          <= '0;
            o_data          <= '0;
            o_wmask         <= '0;
            o_bank_sel      <= '0;
            o_valid         <= 1'b0;
            o_init_complete <= 1'b0;
            o_flush_done    <= 1'b0;
        end else if (!i_halt) begin
            o_flush_done <= 1'b0;
            case (state)
                ST_UNINIT: begin
                    // Post-reset sweep always covers every bank and every row
                    state   <= ST_SWEEP;
                    cnt     <= '0;
                    mask_q  <= '1;
                    base_q  <= '0;
                    count_q <= FULL_COUNT;
                end
                ST_SWEEP: begin
                    cnt <= cnt_next;
                    if (more) begin
                        // Recomputed each cycle; without a transfer cnt_next equals cnt so the beat holds
                        o_valid    <= 1'b1;
                        o_addr     <= addr_next;
                        o_bank_sel <= mask_q;
                        o_data     <= INIT_VALUE;
                        o_wmask    <= '1;
                    end else begin
                        o_valid         <= 1'b0;
                        o_addr          <= '0;
                        o_bank_sel      <= '0;
                        o_data          <= '0;
                        o_wmask         <= '0;
                        o_flush_done    <= 1'b1;
                        o_init_complete <= 1'b1;
                        state           <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (accept) begin
                        state   <= ST_SWEEP;
                        cnt     <= '0;
                        mask_q  <= i_flush_bank_mask;
                        base_q  <= req_base;
                        count_q <= req_count;
                    end
                end
                default: state <= ST_UNINIT;
            endcase
        end
    end

endmodule

// File: tb/tb_status_array_sweeper.sv
`timescale 1ns/1ps
module tb_status_array_sweeper;
    localparam int AW    = 3;
    localparam int RW    = 8;
    localparam int NBLK  = 4;
    localparam int NB    = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [RW-1:0] IV = 8'hA5;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic i_halt = 1'b0;
    logic i_flush_req = 1'b0;
    logic [NB-1:0] i_flush_bank_mask = '0;
`ifdef SWEEP_RANGE_EN
    logic [AW-1:0] i_flush_base = '0;
    logic [AW:0]   i_flush_count = '0;
`endif
    logic i_wr_ready = 1'b1;
    logic [AW-1:0]   o_addr;
    logic [RW-1:0]   o_data;
    logic            o_wen;
    logic [NBLK-1:0] o_wmask;
    logic [NB-1:0]   o_bank_sel;
    logic            o_valid;
    logic            o_init_complete;
    logic            o_ready;
    logic            o_flush_done;

    status_array_sweeper #(
        .ADDR_WIDTH(AW), .ROW_WIDTH(RW), .NUM_BLOCKS(NBLK), .NUM_BANKS(NB), .INIT_VALUE(IV)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_halt(i_halt), .i_flush_req(i_flush_req),
        .i_flush_bank_mask(i_flush_bank_mask),
`ifdef SWEEP_RANGE_EN
        .i_flush_base(i_flush_base), .i_flush_count(i_flush_count),
`endif
        .i_wr_ready(i_wr_ready), .o_addr(o_addr), .o_data(o_data), .o_wen(o_wen),
        .o_wmask(o_wmask), .o_bank_sel(o_bank_sel), .o_valid(o_valid),
        .o_init_complete(o_init_complete), .o_ready(o_ready), .o_flush_done(o_flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mask; int base; int count;
        int stall_at; int stall_len;
        int halt_at;  int halt_len;
        int mid_req_at;
        int exp_beats; int exp_done;
    } vec_t;

    typedef struct { logic [AW-1:0] addr; logic [NB-1:0] sel; } beat_t;

    beat_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({o_valid, o_wen, o_addr, o_bank_sel, o_data, o_wmask, o_flush_done, o_init_complete});
    endfunction

    // Reference model: expected beat stream for one sweep
    task automatic push_model(input vec_t v, input bit post);
        int n; int b; int m;
        beat_t bt;
        if (post) begin
            n = DEPTH; b = 0; m = 3;
        end else begin
`ifdef SWEEP_RANGE_EN
            n = (v.count > DEPTH) ? DEPTH : v.count;
            b = v.base;
`else
            n = DEPTH; b = 0;
`endif
            m = v.mask;
            if (m == 0) n = 0;
        end
        for (int i = 0; i < n; i++) begin
            bt.addr = AW'((b + i) % DEPTH);
            bt.sel  = NB'(m);
            sb.push_back(bt);
        end
    endtask

    // Runs one sweep; edge 1 is the accept edge (or first edge after reset release)
    task automatic run_sweep(input vec_t v, input bit post, input string tag);
        int edges; int beats; int stall_left; int halt_left;
        bit done; bit held;
        logic [31:0] snap;
        logic exp_init;
        beat_t e;
        exp_init = post ? 1'b0 : 1'b1;
        stall_left = v.stall_len;
        halt_left = v.halt_len;
        beats = 0;
        done = 1'b0;
        push_model(v, post);
        if (!post) begin
            chk({tag, "_ready_before"}, 32'(o_ready), 32'd1);
            i_flush_bank_mask = NB'(v.mask);
`ifdef SWEEP_RANGE_EN
            i_flush_base  = AW'(v.base);
            i_flush_count = (AW+1)'(v.count);
`endif
            i_flush_req = 1'b1;
        end
        @(posedge clk); #1;
        i_flush_req = 1'b0;
        edges = 1;
        while (!done && edges < 80) begin
            i_wr_ready = 1'b1; i_halt = 1'b0; i_flush_req = 1'b0;
            if (o_valid && beats == v.stall_at && stall_left > 0) begin
                i_wr_ready = 1'b0; stall_left--;
            end
            if (o_valid && beats == v.halt_at && halt_left > 0) begin
                i_halt = 1'b1; halt_left--;
            end
            if (o_valid && beats == v.mid_req_at) begin
                i_flush_req = 1'b1; i_flush_bank_mask = 2'b01;
            end
            held = !i_wr_ready || i_halt;
            snap = outs();
            @(negedge clk);
            chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
            chk({tag, "_init"}, 32'(o_init_complete), 32'(exp_init));
            if (o_valid && i_wr_ready && !i_halt) begin
                if (sb.size() == 0) begin
                    chk({tag, "_extra_beat"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_beat"}, 32'({o_wen, o_addr, o_bank_sel, o_data, o_wmask}),
                        32'({1'b1, e.addr, e.sel, IV, 4'hF}));
                end
                beats++;
            end
            @(posedge clk); #1;
            edges++;
            if (held) chk({tag, "_hold"}, outs(), snap);
            done = o_flush_done;
        end
        i_wr_ready = 1'b1; i_halt = 1'b0; i_flush_req = 1'b0;
        chk({tag, "_done_edge"}, 32'(edges), 32'(v.exp_done));
        chk({tag, "_beats"}, 32'(beats), 32'(v.exp_beats));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_end_state"}, 32'({o_valid, o_init_complete, o_ready}), 32'b011);
        sb.delete();
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(o_flush_done), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk({tag, "_idle"}, 32'({o_valid, o_ready}), 32'b01);
        end
    endtask

    initial begin
        vec_t vt[6];
        int nv;
        bit found;
        //          mask base cnt stl_at stl_n hlt_at hlt_n mid beats done
        vt[0] = '{3, 0, 8, -1, 0, -1, 0, -1, 8, 10};
`ifdef SWEEP_RANGE_EN
        vt[1] = '{3, 6, 4, -1, 0, -1, 0, -1, 4, 6};
        vt[2] = '{2, 0, 8, -1, 0, -1, 0,  3, 8, 10};
        vt[3] = '{1, 0, 8, -1, 0,  3, 5, -1, 8, 15};
        vt[4] = '{3, 0, 0, -1, 0, -1, 0, -1, 0, 2};
        vt[5] = '{3, 2, 15, 6, 3, -1, 0, -1, 8, 13};
        nv = 6;
`else
        vt[1] = '{3, 0, 8,  4, 3, -1, 0, -1, 8, 13};
        vt[2] = '{2, 0, 8, -1, 0, -1, 0,  3, 8, 10};
        vt[3] = '{1, 0, 8, -1, 0,  3, 5, -1, 8, 15};
        vt[4] = '{0, 0, 8, -1, 0, -1, 0, -1, 0, 2};
        vt[5] = vt[0];
        nv = 5;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd0);
        arst_n = 1'b1;
        run_sweep(vt[0], 1'b1, "post_reset");

        for (int i = 1; i < nv; i++) run_sweep(vt[i], 1'b0, $sformatf("v%0d", i));

        // A request under halt in READY is not accepted
        i_halt = 1'b1; i_flush_req = 1'b1; i_flush_bank_mask = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("halt_ready", 32'(o_ready), 32'd0);
        end
        @(posedge clk); #1;
        i_halt = 1'b0; i_flush_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("halt_no_accept", 32'({o_valid, o_ready}), 32'b01);
        end

        // Reset in the middle of a flush restarts a full post-reset sweep
        i_flush_bank_mask = 2'b01;
`ifdef SWEEP_RANGE_EN
        i_flush_base = '0; i_flush_count = 4'd8;
`endif
        i_flush_req = 1'b1;
        @(posedge clk); #1;
        i_flush_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk); #1;
            if (o_valid && o_addr == 3'd5) found = 1'b1;
        end
        chk("rst_mid_found", 32'(found), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs(), 32'd0);
        chk("rst_mid_ready", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        run_sweep(vt[0], 1'b1, "rst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
